miriscv_mem_arbiter: RTL and testbench
======================================

MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning the number of cycles from mem_req_o to valid mem_rdata_i; legal values are 1..4.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32: the fetch requester, read-only.
REQ-005 SHALL have data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32: the load/store requester.
REQ-006 SHALL have mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_rdata_i in 32: the single shared RAM port.

Function
REQ-007 SHALL use FSM states IDLE and BUSY plus a latency counter cnt of width 3.
REQ-008 SHALL issue a grant only when in IDLE, or in BUSY on the cycle where cnt==1 (the response cycle), so back-to-back accesses are possible.
REQ-009 SHALL grant combinationally in the same cycle as the request; at most one of instr_gnt_o and data_gnt_o is high in a cycle.
REQ-010 SHALL, in the grant cycle, drive mem_req_o=1 and copy the winner's addr, we, be and wdata to the mem_* outputs; an instr grant forces mem_we_o=0 and mem_be_o=4'hF.
REQ-011 SHALL drive mem_req_o=0, mem_we_o=0 and all other mem_* outputs to 0 in every non-grant cycle.
REQ-012 SHALL, on a grant, register the owner, set cnt=MEM_LATENCY and enter BUSY; cnt decrements by 1 every BUSY cycle.
REQ-013 SHALL assert the owner's rvalid for exactly one cycle, MEM_LATENCY cycles after the grant, with owner rdata equal to mem_rdata_i.
REQ-014 SHALL drive the non-owner's rvalid to 0 and both rdata outputs to 0 whenever the corresponding rvalid is 0.
REQ-015 SHALL return an rvalid for writes too, with rdata forced to 0.
REQ-016 SHALL, on the response cycle, go to BUSY with a new cnt if a new grant is issued; otherwise it goes to IDLE.
REQ-017 SHALL NOT assert a gnt to a requester whose req is low.
REQ-018 SHALL give priority to data over instr when both requests are high and ARB_RR_EN is not defined; instr may starve while data_req_i is held high.
REQ-019 SHALL keep a requester's req, addr, we, be and wdata as the requester's responsibility to hold until its gnt; the arbiter does not latch ungranted requests.

Reset
REQ-020 SHALL, while rst_n_i=1 at a clock edge, set state=IDLE, cnt=0, owner=data and last-granted=data, with all gnt, rvalid and mem_req_o outputs at 0.
REQ-021 SHALL suppress combinational grants and mem_req_o during any cycle where rst_n_i=1.
REQ-022 SHALL, on a reset asserted mid-BUSY, drop the outstanding response: no rvalid is produced after reset deasserts.

Configuration
REQ-023 SHALL, when macro MIRISCV_ARB_RR_EN is defined, arbitrate simultaneous requests round-robin: the requester not granted last wins, and the last-granted register updates on every grant.
REQ-024 SHALL, when MIRISCV_ARB_RR_EN is undefined, use the fixed priority of REQ-018; the last-granted register is then absent or unused.

Verification
REQ-025 SHALL cover this scenario: MEM_LATENCY=1, instr_req_i=1 with addr 0x10 for 3 cycles, data idle -> instr_gnt_o high 3 consecutive cycles, mem_addr_o=0x10, and instr_rvalid_o high on cycles 2-4 carrying mem_rdata_i.
REQ-026 SHALL cover this scenario: both requests high in the same cycle, data_we_i=1, be=4'b0011, wdata=0xDEADBEEF, fixed priority -> data_gnt_o=1 and instr_gnt_o=0; mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=0xDEADBEEF; data_rvalid_o one cycle later with data_rdata_o=0.
REQ-027 SHALL cover this scenario: MIRISCV_ARB_RR_EN defined and both requests held high for 4 grants -> grants alternate data, instr, data, instr.
REQ-028 SHALL cover this scenario: MEM_LATENCY=3, data read at addr 0x40 -> no grant for 2 cycles, data_rvalid_o on cycle +3, and an instr request pending since cycle +1 is granted on cycle +3.
REQ-029 SHALL cover this scenario: MEM_LATENCY=2, reset asserted 1 cycle after a data grant -> data_rvalid_o never asserts, and the first request after reset is granted in IDLE.
REQ-030 SHALL cover this scenario: both requests low -> mem_req_o=0 and all mem_* outputs equal 0 every cycle.

Source files
------------

// File: rtl/miriscv_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one fixed-latency RAM port.
// Define MIRISCV_ARB_RR_EN for round-robin arbitration; fixed data-first priority otherwise.
module miriscv_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [2:0] Lat = 3'(MEM_LATENCY);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;  // 1: fetch owns the outstanding access
  logic       we_q, we_d;
  logic       resp, can_grant, grant_instr, grant_data;
`ifdef MIRISCV_ARB_RR_EN
  logic       last_q, last_d;    // 1: fetch was granted last
`endif

  always_comb begin
    resp        = (state_q == StBusy) && (cnt_q == 3'd1) && !rst_n_i;
    can_grant   = !rst_n_i && ((state_q == StIdle) || resp);
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (can_grant) begin
`ifdef MIRISCV_ARB_RR_EN
      if (instr_req_i && data_req_i) begin
        grant_instr = ~last_q;
        grant_data  = last_q;
      end else begin
        grant_instr = instr_req_i;
        grant_data  = data_req_i;
      end
`else
      grant_data  = data_req_i;
      grant_instr = instr_req_i && !data_req_i;
`endif
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (grant_data) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (grant_instr) begin
      mem_req_o   = 1'b1;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
    end
  end

  assign instr_gnt_o    = grant_instr;
  assign data_gnt_o     = grant_data;
  assign instr_rvalid_o = resp && owner_q;
  assign data_rvalid_o  = resp && !owner_q;
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
  // Write responses carry no data.
  assign data_rdata_o   = (data_rvalid_o && !we_q) ? mem_rdata_i : 32'h0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
`ifdef MIRISCV_ARB_RR_EN
    last_d  = last_q;
`endif
    if (state_q == StBusy) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = StIdle;
      end
    end
    if (grant_instr || grant_data) begin
      state_d = StBusy;
      cnt_d   = Lat;
      owner_d = grant_instr;
      we_d    = grant_data && data_we_i;
`ifdef MIRISCV_ARB_RR_EN
      last_d  = grant_instr;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
`ifdef MIRISCV_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
`ifdef MIRISCV_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Scoreboard bench: three arbiters with MEM_LATENCY 1, 2 and 3 share clock, reset and RAM data.
module tb_miriscv_mem_arbiter;

  typedef struct {
    int          dut;
    int          cyc;
    string       tag;
    logic        igt;
    logic        dgt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } out_t;

  typedef struct {
    int          dut;
    int          cyc;
    logic        instr;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM read data is stamped with the current cycle number.
  logic [31:0] mem_rdata;
  assign mem_rdata = {16'hC0DE, cyc[15:0]};

  logic        instr_req    [3];
  logic [31:0] instr_addr   [3];
  logic        instr_gnt    [3];
  logic        instr_rvalid [3];
  logic [31:0] instr_rdata  [3];
  logic        data_req     [3];
  logic        data_we      [3];
  logic [3:0]  data_be      [3];
  logic [31:0] data_addr    [3];
  logic [31:0] data_wdata   [3];
  logic        data_gnt     [3];
  logic        data_rvalid  [3];
  logic [31:0] data_rdata   [3];
  logic        mem_req      [3];
  logic        mem_we       [3];
  logic [3:0]  mem_be       [3];
  logic [31:0] mem_addr     [3];
  logic [31:0] mem_wdata    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    miriscv_mem_arbiter #(.MEM_LATENCY(g + 1)) u_dut (
      .clk_i         (clk),
      .rst_n_i       (rst),
      .instr_req_i   (instr_req[g]),
      .instr_addr_i  (instr_addr[g]),
      .instr_gnt_o   (instr_gnt[g]),
      .instr_rvalid_o(instr_rvalid[g]),
      .instr_rdata_o (instr_rdata[g]),
      .data_req_i    (data_req[g]),
      .data_we_i     (data_we[g]),
      .data_be_i     (data_be[g]),
      .data_addr_i   (data_addr[g]),
      .data_wdata_i  (data_wdata[g]),
      .data_gnt_o    (data_gnt[g]),
      .data_rvalid_o (data_rvalid[g]),
      .data_rdata_o  (data_rdata[g]),
      .mem_req_o     (mem_req[g]),
      .mem_we_o      (mem_we[g]),
      .mem_be_o      (mem_be[g]),
      .mem_addr_o    (mem_addr[g]),
      .mem_wdata_o   (mem_wdata[g]),
      .mem_rdata_i   (mem_rdata)
    );
  end

  out_t out_q [$];
  rsp_t rsp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   skip_rsp = 1'b0;
  bit   done = 1'b0;
  bit   fin = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of stimulus on arbiter k and queues the expected outputs.
  task automatic step(input int k, input string tag, input logic r,
                      input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [3:0] db,
                      input logic [31:0] da, input logic [31:0] dd,
                      input logic eig, input logic edg);
    out_t o;
    rsp_t p;
    @(posedge clk);
    #1;
    rst           = r;
    instr_req[k]  = ir;
    instr_addr[k] = ia;
    data_req[k]   = dr;
    data_we[k]    = dw;
    data_be[k]    = db;
    data_addr[k]  = da;
    data_wdata[k] = dd;
    o.dut   = k;
    o.cyc   = cyc;
    o.tag   = tag;
    o.igt   = eig;
    o.dgt   = edg;
    o.we    = edg ? dw : 1'b0;
    o.be    = edg ? db : (eig ? 4'hF : 4'h0);
    o.addr  = edg ? da : (eig ? ia : 32'h0);
    o.wdata = edg ? dd : 32'h0;
    out_q.push_back(o);
    if ((eig || edg) && !skip_rsp) begin
      p.dut   = k;
      p.cyc   = cyc + k + 1;
      p.instr = eig;
      p.rdata = (edg && dw) ? 32'h0 : {16'hC0DE, 16'(cyc + k + 1)};
      rsp_q.push_back(p);
    end
  endtask

  task automatic idle(input int k, input string tag);
    step(k, tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    out_t o;
    rsp_t p;
    while (out_q.size() > 0 && out_q[0].cyc == cyc) begin
      o = out_q.pop_front();
      chk({o.tag, ".instr_gnt"}, 32'(instr_gnt[o.dut]), 32'(o.igt));
      chk({o.tag, ".data_gnt"}, 32'(data_gnt[o.dut]), 32'(o.dgt));
      chk({o.tag, ".mem_req"}, 32'(mem_req[o.dut]), 32'(o.igt | o.dgt));
      chk({o.tag, ".mem_we"}, 32'(mem_we[o.dut]), 32'(o.we));
      chk({o.tag, ".mem_be"}, 32'(mem_be[o.dut]), 32'(o.be));
      chk({o.tag, ".mem_addr"}, mem_addr[o.dut], o.addr);
      chk({o.tag, ".mem_wdata"}, mem_wdata[o.dut], o.wdata);
    end
    for (int k = 0; k < 3; k++) begin
      if (instr_rvalid[k] || data_rvalid[k]) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rvalid: dut%0d cycle %0d got rvalid, required none", k, cyc);
        end else begin
          p = rsp_q.pop_front();
          chk("rsp.dut", 32'(k), 32'(p.dut));
          chk("rsp.cycle", 32'(cyc), 32'(p.cyc));
          chk("rsp.owner", 32'({instr_rvalid[k], data_rvalid[k]}),
              p.instr ? 32'h2 : 32'h1);
          chk("rsp.rdata", p.instr ? instr_rdata[k] : data_rdata[k], p.rdata);
        end
      end
      if (!instr_rvalid[k]) chk("instr_rdata_idle_zero", instr_rdata[k], 32'h0);
      if (!data_rvalid[k]) chk("data_rdata_idle_zero", data_rdata[k], 32'h0);
    end
    if (done && !fin) begin
      chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
      chk("out_queue_drained", 32'(out_q.size()), 32'h0);
      fin = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      instr_req[k]  = 1'b0;
      instr_addr[k] = 32'h0;
      data_req[k]   = 1'b0;
      data_we[k]    = 1'b0;
      data_be[k]    = 4'h0;
      data_addr[k]  = 32'h0;
      data_wdata[k] = 32'h0;
    end

    // Requests during reset must not be granted.
    step(0, "rst_sup0", 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0);
    step(0, "rst_sup1", 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0);
    idle(0, "post_rst");

    // Latency 1: fetch held for three cycles, back-to-back grants.
    for (int i = 0; i < 3; i++)
      step(0, "fetch_b2b", 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(0, "fetch_drain");

    // Simultaneous requests, data write wins; held fetch wins the response cycle.
    step(0, "both_wr", 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 4'b0011, 32'h80, 32'hDEADBEEF,
         1'b0, 1'b1);
    step(0, "fetch_held", 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(0, "data_rd", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1100, 32'h44, 32'h0, 1'b0, 1'b1);
    idle(0, "wr_drain");

    // Contention: round-robin alternates after a fetch-only grant; fixed priority starves fetch.
    step(0, "fetch_only", 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
`ifdef MIRISCV_ARB_RR_EN
      step(0, "rr_alt", 1'b0, 1'b1, 32'h34, 1'b1, 1'b0, 4'hF, 32'h90, 32'h0,
           (i % 2) == 1, (i % 2) == 0);
`else
      step(0, "fixed_prio", 1'b0, 1'b1, 32'h34, 1'b1, 1'b0, 4'hF, 32'h90, 32'h0, 1'b0, 1'b1);
`endif
    end
    idle(0, "contend_drain");

    // Latency 3: fetch pending from +1 waits until the response cycle +3.
    step(2, "l3_data_rd", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 1'b1);
    step(2, "l3_wait1", 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(2, "l3_wait2", 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(2, "l3_resp_gnt", 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(2, "l3_drain");

    // Latency 2: reset one cycle after a data grant drops the response.
    skip_rsp = 1'b1;
    step(1, "l2_data_rd", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0, 1'b0, 1'b1);
    skip_rsp = 1'b0;
    step(1, "l2_rst_busy", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h64, 32'h0, 1'b0, 1'b0);
    step(1, "l2_gnt_idle", 1'b0, 1'b1, 32'h70, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1, "l2_drain");

    // No requests: RAM port stays quiet on every instance.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 2; i++) idle(k, "quiet");

    done = 1'b1;
    repeat (3) @(posedge clk);
    if (!fin) begin
      n_errors++;
      $display("FAIL final_check: got not run, required run");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
